clock_enable_sched: RTL and testbench

- Schedules two independent clock-enable channels (A, B) from the single system clock.
- Each channel emits one-cycle `ce` pulses at a programmable divisor. Downstream logic (CPU core, PPU/timer) runs on `clk_in` gated by these enables instead of on derived clocks.
- Divisor changes arrive through a valid/ready config port. They are applied only at a channel's period boundary, so pulse spacing never glitches.
- A per-channel pause freezes a channel in phase.

---
 rtl/clock_enable_sched.sv | 110 +++++++++++
 tb/tb_clock_enable_sched.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/clock_enable_sched.sv
// clock_enable_sched: two independent clock-enable channels (A, B) driven from
// one system clock. Each channel issues a one-cycle ce pulse every div+1
// cycles. Divisor updates arrive through a valid/ready port and take effect
// only at a period boundary, or on the next edge when the channel is paused.
module clock_enable_sched #(
  parameter int          CNT_W      = 8,
  parameter int unsigned DIV_A_INIT = 3,
  parameter int unsigned DIV_B_INIT = 1
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             pause_a,
  input  logic             pause_b,
  input  logic             cfg_valid,
  input  logic             cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             ce_a,
  output logic             ce_b,
  output logic [1:0]       cfg_done,
  output logic             sync
);

  // Channel state, index 0 = A, index 1 = B
  logic [CNT_W-1:0] cnt      [2];
  logic [CNT_W-1:0] div      [2];
  logic [CNT_W-1:0] pend_div [2];
  logic [1:0]       pend;

  logic [CNT_W-1:0] cnt_nxt      [2];
  logic [CNT_W-1:0] div_nxt      [2];
  logic [CNT_W-1:0] pend_div_nxt [2];
  logic [1:0]       pend_nxt;
  logic [1:0]       ce_nxt;
  logic [1:0]       done_nxt;
  logic [1:0]       pause;

  assign pause = {pause_b, pause_a};

  // A channel with a stored update refuses a new one until it has applied it.
  assign cfg_ready = ~pend[cfg_ch];

  // Next-state logic: count/wrap, apply pending divisors, accept config.
  always_comb begin
    pend_nxt = pend;
    ce_nxt   = 2'b00;
    done_nxt = 2'b00;
    for (int i = 0; i < 2; i++) begin
      cnt_nxt[i]      = cnt[i];
      div_nxt[i]      = div[i];
      pend_div_nxt[i] = pend_div[i];
      if (pause[i]) begin
        // Frozen in phase; a pending divisor is applied right away.
        if (pend[i]) begin
          div_nxt[i]  = pend_div[i];
          cnt_nxt[i]  = '0;
          pend_nxt[i] = 1'b0;
          done_nxt[i] = 1'b1;
        end
      end else if (cnt[i] == div[i]) begin
        cnt_nxt[i] = '0;
        ce_nxt[i]  = 1'b1;
        // Period boundary: the only glitch-free point to switch divisor.
        if (pend[i]) begin
          div_nxt[i]  = pend_div[i];
          pend_nxt[i] = 1'b0;
          done_nxt[i] = 1'b1;
        end
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
    // A transfer is only possible while pend[cfg_ch] is clear, so it never
    // collides with an apply on the same channel; it is stored, not applied.
    if (cfg_valid && cfg_ready) begin
      pend_nxt[cfg_ch]     = 1'b1;
      pend_div_nxt[cfg_ch] = cfg_div;
    end
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      cnt[0]      <= '0;
      cnt[1]      <= '0;
      div[0]      <= CNT_W'(DIV_A_INIT);
      div[1]      <= CNT_W'(DIV_B_INIT);
      pend_div[0] <= '0;
      pend_div[1] <= '0;
      pend        <= 2'b00;
      ce_a        <= 1'b0;
      ce_b        <= 1'b0;
      cfg_done    <= 2'b00;
      sync        <= 1'b0;
    end else begin
      cnt[0]      <= cnt_nxt[0];
      cnt[1]      <= cnt_nxt[1];
      div[0]      <= div_nxt[0];
      div[1]      <= div_nxt[1];
      pend_div[0] <= pend_div_nxt[0];
      pend_div[1] <= pend_div_nxt[1];
      pend        <= pend_nxt;
      ce_a        <= ce_nxt[0];
      ce_b        <= ce_nxt[1];
      cfg_done    <= done_nxt;
      sync        <= ce_nxt[0] & ce_nxt[1];
    end
  end

endmodule

// File: tb/tb_clock_enable_sched.sv
// Testbench for clock_enable_sched: directed scenarios followed by random
// pause/config traffic, compared against a countdown-based reference model.
module tb_clock_enable_sched;

  localparam int CNT_W = 8;

  logic             clk_in = 1'b0;
  logic             reset_n;
  logic             pause_a, pause_b;
  logic             cfg_valid, cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready, ce_a, ce_b, sync;
  logic [1:0]       cfg_done;

  int vectors = 0;
  int miscompares = 0;

  clock_enable_sched #(.CNT_W(CNT_W), .DIV_A_INIT(3), .DIV_B_INIT(1)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .pause_a(pause_a), .pause_b(pause_b),
    .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .ce_a(ce_a), .ce_b(ce_b), .cfg_done(cfg_done),
    .sync(sync)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: per channel, edges remaining until the next pulse
  // (rem), the current period, and at most one queued divisor.
  int rem [2];
  int period [2];
  int pq [2][$];
  int init_div [2] = '{3, 1};
  logic [1:0] exp_ce, exp_done;
  logic exp_sync;
  bit last_xfer;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      period[i] = init_div[i] + 1;
      rem[i]    = period[i];
      pq[i].delete();
    end
    exp_ce = 2'b00; exp_done = 2'b00; exp_sync = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check cfg_ready, clock, advance model, check outputs.
  task automatic step(input bit pa, input bit pb, input bit v, input bit ch, input int d);
    bit p [2];
    bit rdy;
    pause_a = pa; pause_b = pb; cfg_valid = v; cfg_ch = ch; cfg_div = CNT_W'(d);
    p[0] = pa; p[1] = pb;
    #1;
    rdy = (pq[ch].size() == 0);
    chk("cfg_ready", {7'd0, cfg_ready}, {7'd0, rdy});
    @(posedge clk_in);
    exp_ce = 2'b00; exp_done = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (p[i]) begin
        if (pq[i].size() != 0) begin
          period[i] = pq[i].pop_front() + 1;
          rem[i] = period[i];
          exp_done[i] = 1'b1;
        end
      end else begin
        rem[i]--;
        if (rem[i] == 0) begin
          exp_ce[i] = 1'b1;
          if (pq[i].size() != 0) begin
            period[i] = pq[i].pop_front() + 1;
            exp_done[i] = 1'b1;
          end
          rem[i] = period[i];
        end
      end
    end
    last_xfer = v && rdy;
    if (last_xfer) pq[ch].push_back(d);
    exp_sync = exp_ce[0] & exp_ce[1];
    #1;
    chk("ce_a", {7'd0, ce_a}, {7'd0, exp_ce[0]});
    chk("ce_b", {7'd0, ce_b}, {7'd0, exp_ce[1]});
    chk("cfg_done", {6'd0, cfg_done}, {6'd0, exp_done});
    chk("sync", {7'd0, sync}, {7'd0, exp_sync});
  endtask

  task automatic reset_edge();
    reset_n = 1'b0;
    pause_a = 1'b0; pause_b = 1'b0; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_div = '0;
    @(posedge clk_in);
    model_reset();
    #1;
    chk("rst_ce_a", {7'd0, ce_a}, 8'd0);
    chk("rst_ce_b", {7'd0, ce_b}, 8'd0);
    chk("rst_cfg_done", {6'd0, cfg_done}, 8'd0);
    chk("rst_sync", {7'd0, sync}, 8'd0);
    cfg_ch = 1'b0; #1;
    chk("rst_ready_a", {7'd0, cfg_ready}, 8'd1);
    cfg_ch = 1'b1; #1;
    chk("rst_ready_b", {7'd0, cfg_ready}, 8'd1);
    reset_n = 1'b1;
  endtask

  bit req_on, req_ch;
  int req_div;

  initial begin
    reset_n = 1'b0;
    pause_a = 1'b0; pause_b = 1'b0; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_div = '0;
    model_reset();
    reset_edge();
    reset_edge();

    // Default timeline: ce_a on 4, 8; ce_b on 2, 4; sync on 4.
    for (int k = 1; k <= 4; k++) step(0, 0, 0, 0, 0);
    chk("ce_a_cycle4", {7'd0, ce_a}, 8'd1);
    chk("sync_cycle4", {7'd0, sync}, 8'd1);
    // Cycle 5: A -> div 7, applied at cycle 8.
    step(0, 0, 1, 0, 7);
    for (int k = 6; k <= 8; k++) step(0, 0, 0, 0, 0);
    chk("done_cycle8", {6'd0, cfg_done}, 8'd1);
    // Pause A for five cycles, then run on.
    for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 0);

    // Paused B takes div 0 on the next edge, then pulses every cycle.
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 1, 0);
    chk("done_b_paused", {6'd0, cfg_done}, 8'd2);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 1, 0);
    chk("ce_b_cont", {7'd0, ce_b}, 8'd1);

    // Back-to-back A requests; a B request transfers meanwhile.
    step(0, 0, 1, 0, 2);
    step(0, 0, 1, 1, 4);
    for (int k = 0; k < 20; k++) step(0, 0, 1, 0, 5);
    // Queue an A update, then reset before it applies.
    step(0, 0, 1, 0, 6);
    reset_edge();
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0);

    // Random pauses and held-valid config requests.
    req_on = 0; req_ch = 0; req_div = 0;
    for (int k = 0; k < 500; k++) begin
      if (!req_on && ($urandom_range(0, 2) == 0)) begin
        req_on = 1; req_ch = 1'($urandom_range(0, 1)); req_div = $urandom_range(0, 5);
      end
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, req_on, req_ch, req_div);
      if (last_xfer) req_on = 0;
      if (k == 250) begin
        reset_edge();
        req_on = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
